led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The block SHALL have parameter LED_W, default 8, number of LEDs, a power of two from 2 to 16.
REQ-002 The block SHALL have parameter BLINK_TICKS, default 2, number of ticks per half-period of the fail blink, range 1 to 255.
REQ-003 The block SHALL derive localparam SEL_W = log2(LED_W), default 3, the LED index width.
REQ-004 i_Clk  input  1  system clock, 50 MHz.
REQ-005 i_Rst  input  1  asynchronous, active-low reset.
REQ-006 i_Start  input  1  deglitched start pulse, one cycle wide.
REQ-007 i_Tick  input  1  one-cycle tick, nominally 1 s.
REQ-008 i_State  input  3  game state: 0 idle, 1 game_start, 2 game_clear, 3 game_fail, 4-7 unused.
REQ-009 i_Random  input  SEL_W  random value used for LED selection.
REQ-010 o_Led  output  LED_W  LED drive, registered.
REQ-011 o_LedIdx  output  SEL_W  index of the currently lit target LED, registered.
REQ-012 o_NewTarget  output  1  one-cycle pulse whenever a new target is loaded.

Function
REQ-013 All outputs SHALL be registered on the rising edge of i_Clk; nothing SHALL be combinational from input to output.
REQ-014 The block SHALL register i_State into r_PrevState; entry SHALL be asserted when i_State != r_PrevState.
REQ-015 In idle, when i_Start=1, the block SHALL load o_LedIdx=i_Random and o_Led=one-hot(i_Random), and pulse o_NewTarget.
REQ-016 In idle, when i_Start=0, the block SHALL drive o_Led=0 and hold o_LedIdx.
REQ-017 In game_start, on i_Tick the block SHALL select a new target:
  - candidate = i_Random;
  - if candidate == o_LedIdx, use (candidate+1) mod LED_W (no-repeat rule, wraps from LED_W-1 to 0);
  - load o_LedIdx and the one-hot o_Led, and pulse o_NewTarget.
REQ-018 In game_start without i_Tick, o_Led and o_LedIdx SHALL hold their values, including across entry from idle.
REQ-019 On entry to game_clear the block SHALL load o_Led=1 (bit 0) and o_LedIdx=0.
REQ-020 In game_clear, on each later i_Tick the block SHALL rotate o_Led left by one, bit LED_W-1 wrapping to bit 0, and increment o_LedIdx mod LED_W.
REQ-021 On entry to game_fail the block SHALL load o_Led=all ones and clear the tick counter r_BlinkCnt.
REQ-022 In game_fail, r_BlinkCnt SHALL count ticks from 0 to BLINK_TICKS-1; on the tick where r_BlinkCnt==BLINK_TICKS-1, o_Led SHALL invert (all ones <-> all zeros) and r_BlinkCnt SHALL return to 0.
REQ-023 In states 4-7, o_Led SHALL be 0, o_LedIdx SHALL hold, and o_NewTarget SHALL be 0.
REQ-024 When entry and i_Tick occur in the same cycle, the entry action SHALL win and that tick SHALL be ignored.
REQ-025 In idle, i_Start SHALL take precedence over entry.
REQ-026 o_NewTarget SHALL be 0 in every cycle not covered by REQ-015 or REQ-017.
REQ-027 i_Tick SHALL be ignored in idle.
REQ-028 i_Start SHALL be ignored outside idle.

Reset
REQ-029 While i_Rst=0, regardless of clock, the block SHALL force o_Led=0, o_LedIdx=0, o_NewTarget=0, r_PrevState=0 and r_BlinkCnt=0.
REQ-030 After i_Rst deasserts, the first rising edge SHALL operate per Function; reset asserted mid-blink or mid-chase SHALL abort it immediately.

Verification (LED_W=8, BLINK_TICKS=2)
REQ-031 Idle, i_Start=1, i_Random=5 -> next cycle o_Led=0x20, o_LedIdx=5, o_NewTarget=1; the cycle after, o_Led=0x00.
REQ-032 game_start, o_LedIdx=3, i_Tick with i_Random=3 -> o_Led=0x10, o_LedIdx=4; with o_LedIdx=7 and i_Random=7 -> o_Led=0x01, o_LedIdx=0.
REQ-033 Enter game_clear together with i_Tick -> o_Led=0x01; four more ticks -> 0x02, 0x04, 0x08, 0x10; after eight ticks total the pattern wraps back to 0x01.
REQ-034 Enter game_fail -> o_Led=0xFF; tick 1 -> 0xFF; tick 2 -> 0x00; tick 4 -> 0xFF.
REQ-035 Drive i_State=6 -> o_Led=0x00 and o_NewTarget never asserts.
REQ-036 Assert i_Rst low asynchronously between clock edges during the fail blink -> o_Led=0x00 immediately; after release, idle behaviour resumes.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator for a reaction game: random target, clear chase, fail blink.
// All outputs are registered one cycle after the inputs they depend on; there is no backpressure.
module led_pattern_gen #(
  parameter int LED_W       = 8,
  parameter int BLINK_TICKS = 2,
  localparam int SEL_W      = $clog2(LED_W)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic             i_Tick,
  input  logic [2:0]       i_State,
  input  logic [SEL_W-1:0] i_Random,
  output logic [LED_W-1:0] o_Led,
  output logic [SEL_W-1:0] o_LedIdx,
  output logic             o_NewTarget
);

  localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_TICKS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_CLEAR = 3'd2;
  localparam logic [2:0] ST_FAIL  = 3'd3;

  logic [LED_W-1:0] r_Led;
  logic [SEL_W-1:0] r_LedIdx;
  logic             r_NewTarget;
  logic [2:0]       r_PrevState;
  logic [CNT_W-1:0] r_BlinkCnt;

  logic             w_Entry;
  logic [SEL_W-1:0] w_Cand;
  logic [LED_W-1:0] w_RandHot;
  logic [LED_W-1:0] w_CandHot;
  logic [LED_W-1:0] w_LedNxt;
  logic [SEL_W-1:0] w_IdxNxt;
  logic             w_NewNxt;
  logic [CNT_W-1:0] w_CntNxt;

  assign w_Entry   = (i_State != r_PrevState);
  // No-repeat rule: a repeat of the current target moves one LED on, wrapping naturally.
  assign w_Cand    = (i_Random == r_LedIdx) ? (i_Random + SEL_W'(1)) : i_Random;
  assign w_RandHot = LED_W'(1) << i_Random;
  assign w_CandHot = LED_W'(1) << w_Cand;

  always_comb begin
    w_LedNxt = r_Led;
    w_IdxNxt = r_LedIdx;
    w_NewNxt = 1'b0;
    w_CntNxt = r_BlinkCnt;
    case (i_State)
      ST_IDLE: begin
        if (i_Start) begin
          w_LedNxt = w_RandHot;
          w_IdxNxt = i_Random;
          w_NewNxt = 1'b1;
        end else begin
          w_LedNxt = '0;
        end
      end
      ST_START: begin
        if (!w_Entry && i_Tick) begin
          w_LedNxt = w_CandHot;
          w_IdxNxt = w_Cand;
          w_NewNxt = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (w_Entry) begin
          w_LedNxt = LED_W'(1);
          w_IdxNxt = '0;
        end else if (i_Tick) begin
          w_LedNxt = {r_Led[LED_W-2:0], r_Led[LED_W-1]};
          w_IdxNxt = r_LedIdx + SEL_W'(1);
        end
      end
      ST_FAIL: begin
        if (w_Entry) begin
          w_LedNxt = '1;
          w_CntNxt = '0;
        end else if (i_Tick) begin
          if (r_BlinkCnt == CNT_LAST) begin
            w_LedNxt = ~r_Led;
            w_CntNxt = '0;
          end else begin
            w_CntNxt = r_BlinkCnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_LedNxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_Led       <= '0;
      r_LedIdx    <= '0;
      r_NewTarget <= 1'b0;
      r_PrevState <= '0;
      r_BlinkCnt  <= '0;
    end else begin
      r_Led       <= w_LedNxt;
      r_LedIdx    <= w_IdxNxt;
      r_NewTarget <= w_NewNxt;
      r_PrevState <= i_State;
      r_BlinkCnt  <= w_CntNxt;
    end
  end

  assign o_Led       = r_Led;
  assign o_LedIdx    = r_LedIdx;
  assign o_NewTarget = r_NewTarget;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed vector table, async-reset sequence, random run against a model.
module tb_led_pattern_gen;

  localparam int LED_W = 8;
  localparam int BT    = 2;
  localparam int SEL_W = 3;

  logic             i_Clk;
  logic             i_Rst;
  logic             i_Start;
  logic             i_Tick;
  logic [2:0]       i_State;
  logic [SEL_W-1:0] i_Random;
  logic [LED_W-1:0] o_Led;
  logic [SEL_W-1:0] o_LedIdx;
  logic             o_NewTarget;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state, kept in the game's own terms.
  int         m_idx;
  int         m_prev;
  int         m_fail_ticks;
  logic [7:0] m_led;
  bit         m_new;

  led_pattern_gen #(.LED_W(LED_W), .BLINK_TICKS(BT)) dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Start     (i_Start),
    .i_Tick      (i_Tick),
    .i_State     (i_State),
    .i_Random    (i_Random),
    .o_Led       (o_Led),
    .o_LedIdx    (o_LedIdx),
    .o_NewTarget (o_NewTarget)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_prev = 0; m_fail_ticks = 0; m_led = 8'h00; m_new = 0;
  endtask

  task automatic model_step(input int st, input bit start, input bit tick, input int rnd);
    bit entry;
    int c;
    entry = (st != m_prev);
    m_new = 0;
    case (st)
      0: begin
        if (start) begin m_idx = rnd; m_led = 8'(1 << rnd); m_new = 1; end
        else m_led = 8'h00;
      end
      1: begin
        if (!entry && tick) begin
          c = (rnd == m_idx) ? (rnd + 1) % LED_W : rnd;
          m_idx = c; m_led = 8'(1 << c); m_new = 1;
        end
      end
      2: begin
        if (entry) m_idx = 0;
        else if (tick) m_idx = (m_idx + 1) % LED_W;
        m_led = 8'(1 << m_idx);
      end
      3: begin
        if (entry) m_fail_ticks = 0;
        else if (tick) m_fail_ticks++;
        m_led = (((m_fail_ticks / BT) % 2) != 0) ? 8'h00 : 8'hFF;
      end
      default: m_led = 8'h00;
    endcase
    m_prev = st;
  endtask

  // Drive one cycle of inputs, advance the model on the edge, sample 1 time unit later.
  task automatic step(input logic [2:0] st, input bit start, input bit tick, input logic [2:0] rnd);
    i_State = st; i_Start = start; i_Tick = tick; i_Random = rnd;
    @(posedge i_Clk);
    model_step(int'(st), start, tick, int'(rnd));
    #1;
  endtask

  typedef struct {
    logic [2:0] st;
    bit         start;
    bit         tick;
    logic [2:0] rnd;
    logic [7:0] exp_led;
    logic [2:0] exp_idx;
    bit         exp_new;
  } vec_t;

  vec_t vecs[$];

  initial begin
    i_Rst = 1'b0; i_Start = 1'b0; i_Tick = 1'b0; i_State = 3'd0; i_Random = '0;
    model_reset();
    repeat (2) @(posedge i_Clk);
    #1;
    chk("reset_led", 32'(o_Led), 32'h00);
    chk("reset_idx", 32'(o_LedIdx), 32'h0);
    chk("reset_new", 32'(o_NewTarget), 32'h0);
    #3 i_Rst = 1'b1;
    @(posedge i_Clk); #1;

    //          st  start tick rnd  led    idx new
    vecs.push_back('{3'd0, 1, 0, 3'd5, 8'h20, 3'd5, 1});
    vecs.push_back('{3'd0, 0, 0, 3'd5, 8'h00, 3'd5, 0});
    vecs.push_back('{3'd0, 0, 1, 3'd2, 8'h00, 3'd5, 0});
    vecs.push_back('{3'd1, 0, 1, 3'd1, 8'h00, 3'd5, 0});
    vecs.push_back('{3'd1, 0, 1, 3'd3, 8'h08, 3'd3, 1});
    vecs.push_back('{3'd1, 0, 1, 3'd3, 8'h10, 3'd4, 1});
    vecs.push_back('{3'd1, 1, 0, 3'd1, 8'h10, 3'd4, 0});
    vecs.push_back('{3'd1, 0, 1, 3'd7, 8'h80, 3'd7, 1});
    vecs.push_back('{3'd1, 0, 1, 3'd7, 8'h01, 3'd0, 1});
    vecs.push_back('{3'd2, 0, 1, 3'd4, 8'h01, 3'd0, 0});
    vecs.push_back('{3'd2, 0, 1, 3'd4, 8'h02, 3'd1, 0});
    vecs.push_back('{3'd2, 0, 0, 3'd4, 8'h02, 3'd1, 0});
    vecs.push_back('{3'd2, 0, 1, 3'd4, 8'h04, 3'd2, 0});
    vecs.push_back('{3'd2, 1, 1, 3'd4, 8'h08, 3'd3, 0});
    vecs.push_back('{3'd2, 0, 1, 3'd4, 8'h10, 3'd4, 0});
    vecs.push_back('{3'd2, 0, 1, 3'd4, 8'h20, 3'd5, 0});
    vecs.push_back('{3'd2, 0, 1, 3'd4, 8'h40, 3'd6, 0});
    vecs.push_back('{3'd2, 0, 1, 3'd4, 8'h80, 3'd7, 0});
    vecs.push_back('{3'd2, 0, 1, 3'd4, 8'h01, 3'd0, 0});
    vecs.push_back('{3'd3, 0, 1, 3'd4, 8'hFF, 3'd0, 0});
    vecs.push_back('{3'd3, 0, 1, 3'd4, 8'hFF, 3'd0, 0});
    vecs.push_back('{3'd3, 0, 0, 3'd4, 8'hFF, 3'd0, 0});
    vecs.push_back('{3'd3, 1, 1, 3'd4, 8'h00, 3'd0, 0});
    vecs.push_back('{3'd3, 0, 1, 3'd4, 8'h00, 3'd0, 0});
    vecs.push_back('{3'd3, 0, 1, 3'd4, 8'hFF, 3'd0, 0});
    vecs.push_back('{3'd6, 1, 1, 3'd4, 8'h00, 3'd0, 0});
    vecs.push_back('{3'd6, 0, 0, 3'd4, 8'h00, 3'd0, 0});
    vecs.push_back('{3'd1, 0, 1, 3'd0, 8'h00, 3'd0, 0});
    vecs.push_back('{3'd1, 0, 1, 3'd0, 8'h02, 3'd1, 1});
    vecs.push_back('{3'd0, 1, 0, 3'd7, 8'h80, 3'd7, 1});
    vecs.push_back('{3'd0, 0, 0, 3'd7, 8'h00, 3'd7, 0});

    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].start, vecs[i].tick, vecs[i].rnd);
      chk($sformatf("vec%0d_led", i), 32'(o_Led), 32'(vecs[i].exp_led));
      chk($sformatf("vec%0d_idx", i), 32'(o_LedIdx), 32'(vecs[i].exp_idx));
      chk($sformatf("vec%0d_new", i), 32'(o_NewTarget), 32'(vecs[i].exp_new));
    end

    // Reset pulled low between edges in the middle of the fail blink.
    step(3'd3, 0, 0, 3'd0);
    step(3'd3, 0, 1, 3'd0);
    chk("blink_pre_rst", 32'(o_Led), 32'hFF);
    #2 i_Rst = 1'b0;
    #1;
    chk("async_rst_led", 32'(o_Led), 32'h00);
    chk("async_rst_idx", 32'(o_LedIdx), 32'h0);
    model_reset();
    @(posedge i_Clk);
    #3 i_Rst = 1'b1;
    i_State = 3'd0;
    step(3'd0, 1, 0, 3'd3);
    chk("post_rst_led", 32'(o_Led), 32'h08);
    chk("post_rst_idx", 32'(o_LedIdx), 32'h3);
    chk("post_rst_new", 32'(o_NewTarget), 32'h1);
    step(3'd0, 0, 1, 3'd3);
    chk("post_rst_idle", 32'(o_Led), 32'h00);

    // Random run: states biased towards the four game states, checked against the model.
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [2:0] st;
      r  = int'($urandom_range(0, 15));
      st = (r < 12) ? 3'(r % 4) : 3'(r % 8);
      // Hold the state for a few cycles now and then so chases and blinks progress.
      if ($urandom_range(0, 3) != 0 && n > 0) st = i_State;
      step(st, 1'($urandom % 2), 1'($urandom % 2), 3'($urandom_range(0, 7)));
      chk("rnd_led", 32'(o_Led), 32'(m_led));
      chk("rnd_idx", 32'(o_LedIdx), 32'(m_idx));
      chk("rnd_new", 32'(o_NewTarget), 32'(m_new));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
